// File: rtl/button_value_entry_pkg.sv
// Shared definitions for the button value entry front end: FSM state
// encoding and default debounce timing.
package button_value_entry_pkg;

    // Default debounce length and counter width (2**CNT_W must exceed DEB_CYCLES).
    localparam int DEB_CYCLES_DEFAULT = 250000;
    localparam int CNT_W_DEFAULT      = 18;

    // Width of the bit counter presented to the controller.
    localparam int COUNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENTRY  = 2'd1,
        S_FULL   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/button_value_entry_if.sv
// Signal bundle between the controller/board side and the value entry block.
// The slave side is the entry block; the master side drives buttons and enable.
interface button_value_entry_if
    import button_value_entry_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic               enable;
    logic               btn_zero_n;
    logic               btn_one_n;
    logic               btn_next_n;
    logic [WIDTH-1:0]   value;
    logic               value_ready;
    logic [WIDTH-1:0]   cur_value;
    logic [COUNT_W-1:0] bit_count;

    modport slave (
        input  enable, btn_zero_n, btn_one_n, btn_next_n,
        output value, value_ready, cur_value, bit_count
    );

    modport master (
        output enable, btn_zero_n, btn_one_n, btn_next_n,
        input  value, value_ready, cur_value, bit_count
    );
endinterface

// File: rtl/button_value_entry_btn_conditioner.sv
// Conditions one raw active-low push button: 2-FF synchroniser, debounce
// counter, and a single-cycle pulse on each accepted press.
module btn_conditioner
    import button_value_entry_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic press_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge value of the others; sync2_q must see the old sync1_q.
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive differing samples;
    // emit one pulse when the accepted level becomes pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= sync2_q;
                press_q <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/button_value_entry.sv
// Button value entry: three conditioned buttons feed an MSB-first shift
// register; confirm presents the value to the controller with a ready pulse.
module button_value_entry
    import button_value_entry_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    button_value_entry_if.slave  bus
);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(WIDTH);

    logic zero_ev;
    logic one_ev;
    logic next_ev;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cur_q,   cur_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic [COUNT_W-1:0] cnt_q,   cnt_d;

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_zero (
        .clk(clk), .rst(rst), .btn_n_i(bus.btn_zero_n), .press_o(zero_ev)
    );
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_one (
        .clk(clk), .rst(rst), .btn_n_i(bus.btn_one_n), .press_o(one_ev)
    );
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_next (
        .clk(clk), .rst(rst), .btn_n_i(bus.btn_next_n), .press_o(next_ev)
    );

    // State, shift register, bit counter and committed value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            value_q <= value_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. The value is captured on the confirm event so that it
    // is already valid during the ready cycle; the shift register clears after it.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        cur_d   = cur_q;
        value_d = value_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    state_d = (cnt_q == FULL_COUNT) ? S_FULL : S_ENTRY;
                end
            end
            S_ENTRY, S_FULL: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else if (next_ev) begin
                    value_d = cur_q;
                    state_d = S_COMMIT;
                end else if (state_q == S_ENTRY && (zero_ev ^ one_ev)) begin
                    cur_d = {cur_q[WIDTH-2:0], one_ev};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == FULL_COUNT - 1'b1) begin
                        state_d = S_FULL;
                    end
                end
            end
            S_COMMIT: begin
                cur_d   = '0;
                cnt_d   = '0;
                state_d = bus.enable ? S_ENTRY : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.value       = value_q;
    assign bus.value_ready = (state_q == S_COMMIT);
    assign bus.cur_value   = cur_q;
    assign bus.bit_count   = cnt_q;

endmodule

// File: tb/tb_button_value_entry.sv
// Self-checking bench for button_value_entry with a short debounce window.
// A behavioural model tracks the expected entry value from the press history.
module tb_button_value_entry;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    button_value_entry_if #(.WIDTH(W)) bus ();

    button_value_entry #(.WIDTH(W), .DEB_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_cur   = 0;
    int m_cnt   = 0;
    int m_value = 0;
    bit m_en    = 1'b0;

    // Ready-pulse monitor: totals and a count of back-to-back pulses.
    int         ready_total = 0;
    int         consec_cnt  = 0;
    logic [W-1:0] ready_val = '0;
    bit         prev_ready  = 1'b0;

    always @(negedge clk) begin
        if (bus.value_ready === 1'b1) begin
            ready_total++;
            ready_val = bus.value;
            if (prev_ready) consec_cnt++;
        end
        prev_ready = (bus.value_ready === 1'b1);
    end

    task automatic set_enable(input bit e);
        @(posedge clk); #1;
        bus.enable = e;
        m_en = e;
        repeat (3) @(posedge clk);
    endtask

    // Press the selected buttons together, release, let everything settle,
    // then compare the outputs against the model.
    task automatic apply_press(input bit z, input bit o, input bit n, input int hold,
                               input string tag);
        int r0;
        int exp_ready;
        int exp_val;
        r0 = ready_total;
        exp_ready = 0;
        exp_val = 0;
        @(posedge clk); #1;
        bus.btn_zero_n = ~z;
        bus.btn_one_n  = ~o;
        bus.btn_next_n = ~n;
        repeat (hold) @(posedge clk);
        #1;
        bus.btn_zero_n = 1'b1;
        bus.btn_one_n  = 1'b1;
        bus.btn_next_n = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        if (m_en) begin
            if (n) begin
                exp_ready = 1;
                exp_val   = m_cur;
                m_value   = m_cur;
                m_cur     = 0;
                m_cnt     = 0;
            end else if (z != o && m_cnt < W) begin
                m_cur = (m_cur * 2 + int'(o)) % (1 << W);
                m_cnt = m_cnt + 1;
            end
        end
        n_checks++;
        if (bus.cur_value !== W'(m_cur)) begin
            n_errors++;
            $display("FAIL %s cur_value: got %0h expected %0h", tag, bus.cur_value, m_cur);
        end
        n_checks++;
        if (bus.bit_count !== 4'(m_cnt)) begin
            n_errors++;
            $display("FAIL %s bit_count: got %0d expected %0d", tag, bus.bit_count, m_cnt);
        end
        n_checks++;
        if (ready_total - r0 != exp_ready) begin
            n_errors++;
            $display("FAIL %s ready_pulses: got %0d expected %0d", tag, ready_total - r0, exp_ready);
        end
        n_checks++;
        if (bus.value !== W'(m_value)) begin
            n_errors++;
            $display("FAIL %s value: got %0h expected %0h", tag, bus.value, m_value);
        end
        if (exp_ready == 1) begin
            n_checks++;
            if (ready_val !== W'(exp_val)) begin
                n_errors++;
                $display("FAIL %s value_at_ready: got %0h expected %0h", tag, ready_val, exp_val);
            end
        end
    endtask

    task automatic enter_bits(input logic [W-1:0] bits, input int count, input string tag);
        for (int i = count - 1; i >= 0; i--) begin
            apply_press(~bits[i], bits[i], 1'b0, 10, tag);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.value !== '0 || bus.value_ready !== 1'b0 || bus.cur_value !== '0 ||
            bus.bit_count !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got value=%0h ready=%b cur=%0h cnt=%0d expected all 0",
                     bus.value, bus.value_ready, bus.cur_value, bus.bit_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_cur = 0; m_cnt = 0; m_value = 0;
    endtask

    task automatic test_basic_entry();
        logic [W-1:0] pat;
        pat = 8'b1011_0010;
        set_enable(1'b1);
        enter_bits(pat, 8, "basic_bit");
        apply_press(1'b0, 1'b0, 1'b1, 10, "basic_confirm");
        n_checks++;
        if (bus.value !== 8'hB2) begin
            n_errors++;
            $display("FAIL basic_value: got %0h expected b2", bus.value);
        end
    endtask

    task automatic test_chatter();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            bus.btn_one_n = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            bus.btn_one_n = 1'b1;
            repeat (2) @(posedge clk);
        end
        #1;
        bus.btn_one_n = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        bus.btn_one_n = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        m_cur = 1; m_cnt = 1;
        n_checks++;
        if (bus.cur_value !== 8'h01 || bus.bit_count !== 4'd1) begin
            n_errors++;
            $display("FAIL chatter_single_shift: got cur=%0h cnt=%0d expected cur=01 cnt=1",
                     bus.cur_value, bus.bit_count);
        end
        apply_press(1'b0, 1'b0, 1'b1, 10, "chatter_confirm");
    endtask

    task automatic test_full();
        enter_bits(8'hFF, 8, "full_bit");
        apply_press(1'b1, 1'b0, 1'b0, 10, "full_extra0a");
        apply_press(1'b1, 1'b0, 1'b0, 10, "full_extra0b");
        n_checks++;
        if (bus.cur_value !== 8'hFF || bus.bit_count !== 4'd8) begin
            n_errors++;
            $display("FAIL full_hold: got cur=%0h cnt=%0d expected cur=ff cnt=8",
                     bus.cur_value, bus.bit_count);
        end
        apply_press(1'b0, 1'b0, 1'b1, 10, "full_confirm");
        n_checks++;
        if (bus.value !== 8'hFF) begin
            n_errors++;
            $display("FAIL full_value: got %0h expected ff", bus.value);
        end
    endtask

    task automatic test_partial();
        enter_bits(8'h05, 3, "partial_bit");
        apply_press(1'b0, 1'b0, 1'b1, 10, "partial_confirm");
        n_checks++;
        if (bus.value !== 8'h05) begin
            n_errors++;
            $display("FAIL partial_value: got %0h expected 05", bus.value);
        end
        apply_press(1'b0, 1'b0, 1'b1, 10, "empty_confirm");
        n_checks++;
        if (bus.value !== 8'h00) begin
            n_errors++;
            $display("FAIL empty_value: got %0h expected 00", bus.value);
        end
    endtask

    task automatic test_simultaneous();
        apply_press(1'b0, 1'b1, 1'b0, 10, "simul_setup");
        apply_press(1'b1, 1'b1, 1'b0, 10, "simul_zero_one");
        apply_press(1'b0, 1'b1, 1'b1, 10, "simul_confirm_one");
        n_checks++;
        if (bus.value !== 8'h01) begin
            n_errors++;
            $display("FAIL simul_confirm_value: got %0h expected 01", bus.value);
        end
    endtask

    task automatic test_reset_mid_entry();
        enter_bits(8'h03, 2, "rst_mid_bit");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_cur = 0; m_cnt = 0; m_value = 0;
        @(negedge clk);
        n_checks++;
        if (bus.value !== '0 || bus.value_ready !== 1'b0 || bus.cur_value !== '0 ||
            bus.bit_count !== '0) begin
            n_errors++;
            $display("FAIL rst_mid_outputs: got value=%0h ready=%b cur=%0h cnt=%0d expected all 0",
                     bus.value, bus.value_ready, bus.cur_value, bus.bit_count);
        end
        repeat (3) @(posedge clk);
        apply_press(1'b0, 1'b0, 1'b1, 10, "rst_mid_confirm");
        apply_press(1'b0, 1'b1, 1'b0, 10, "disabled_setup");
        set_enable(1'b0);
        apply_press(1'b0, 1'b1, 1'b0, 10, "disabled_one");
        apply_press(1'b1, 1'b0, 1'b0, 10, "disabled_zero");
        apply_press(1'b0, 1'b0, 1'b1, 10, "disabled_confirm");
        set_enable(1'b1);
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 48; i++) begin
            if ($urandom_range(0, 9) == 0) set_enable(~m_en);
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3: apply_press(1'b0, 1'b1, 1'b0, int'($urandom_range(8, 25)), "rand_one");
                4, 5, 6:    apply_press(1'b1, 1'b0, 1'b0, int'($urandom_range(8, 25)), "rand_zero");
                7:          apply_press(1'b0, 1'b0, 1'b1, int'($urandom_range(8, 25)), "rand_confirm");
                8:          apply_press(1'b1, 1'b1, 1'b0, int'($urandom_range(8, 25)), "rand_both");
                default:    apply_press($urandom_range(0, 1) == 1, 1'b0, 1'b1,
                                        int'($urandom_range(8, 25)), "rand_confirm_bit");
            endcase
        end
        set_enable(1'b1);
        apply_press(1'b0, 1'b0, 1'b1, 10, "rand_final_confirm");
    endtask

    task automatic test_back_to_back();
        n_checks++;
        if (consec_cnt != 0) begin
            n_errors++;
            $display("FAIL ready_back_to_back: got %0d consecutive pulses expected 0", consec_cnt);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.enable     = 1'b0;
        bus.btn_zero_n = 1'b1;
        bus.btn_one_n  = 1'b1;
        bus.btn_next_n = 1'b1;
        test_reset();
        test_basic_entry();
        test_chatter();
        test_full();
        test_partial();
        test_simultaneous();
        test_reset_mid_entry();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
